// File: rtl/intr_pkg.sv
// Shared interrupt-controller definitions: dispatcher states, controller io map,
// source numbering and the default set of sources that need a clear write.
package intr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_PEND  = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_WAIT_EOI = 3'd4
  } intr_disp_state_t;

  localparam int unsigned INTR_NSRC = 5;

  localparam logic [3:0] INTR_PEND_ADDR   = 4'd0;
  localparam logic [3:0] INTR_STATUS_ADDR = 4'd1;
  localparam logic [3:0] INTR_ENABLE_ADDR = 4'd2;
  localparam logic [3:0] INTR_SET_ADDR    = 4'd4;
  localparam logic [3:0] INTR_CLR_ADDR    = 4'd5;

  localparam int unsigned SRC_UART  = 0;
  localparam int unsigned SRC_CLOCK = 1;
  localparam int unsigned SRC_TIMER = 2;
  localparam int unsigned SRC_SWI   = 3;
  localparam int unsigned SRC_SD    = 4;

  // Level sources (uart, sd) clear themselves when the device is serviced.
  localparam logic [INTR_NSRC-1:0] INTR_CLR_MASK = 5'b01110;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: lowest-numbered asserted request wins.
// Shared with the CPU trap unit.
module intr_prio_enc #(
  parameter int NSRC = 5,
  parameter int IDXW = 3
) (
  input  logic [NSRC-1:0] req_i,
  output logic            any_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDXW'(i);
    end
  end

endmodule

// File: rtl/intr_dispatch.sv
// Interrupt dispatcher: reads the controller's pending register, offers the
// lowest pending source to the CPU, clears it if needed and waits for EOI.
// Optional event counters under INTR_DISPATCH_STATS_EN.
module intr_dispatch
  import intr_pkg::*;
#(
  parameter int                NSRC      = INTR_NSRC,
  parameter logic [3:0]        PEND_ADDR = INTR_PEND_ADDR,
  parameter logic [3:0]        CLR_ADDR  = INTR_CLR_ADDR,
  parameter logic [NSRC-1:0]   CLR_MASK  = INTR_CLR_MASK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        cpu_ie,
  output logic        io_req,
  input  logic        io_gnt,
  output logic        io_write,
  output logic [3:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        irq_valid,
  output logic [2:0]  irq_vec,
  input  logic        irq_ready,
  input  logic        irq_eoi,
`ifdef INTR_DISPATCH_STATS_EN
  output logic [7:0]  spurious_count,
  output logic [15:0] dispatch_count,
`endif
  output logic        busy
);

  intr_disp_state_t state_q, state_d;
  logic [2:0]       src_q, src_d;
  logic             pend_any;
  logic [2:0]       pend_idx;
  logic             unused_rdata;

  assign unused_rdata = ^io_rdata[15:NSRC];

  intr_prio_enc #(.NSRC(NSRC), .IDXW(3)) u_enc (
    .req_i (io_rdata[NSRC-1:0]),
    .any_o (pend_any),
    .idx_o (pend_idx)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    unique case (state_q)
      ST_IDLE:     if (interrupt && cpu_ie) state_d = ST_RD_PEND;
      ST_RD_PEND: begin
        if (!cpu_ie) begin
          state_d = ST_IDLE;
        end else if (io_gnt) begin
          if (pend_any) begin
            src_d   = pend_idx;
            state_d = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PRESENT: begin
        // A completed handshake takes precedence over a same-cycle cpu_ie drop.
        if (irq_ready)   state_d = CLR_MASK[src_q] ? ST_CLEAR : ST_WAIT_EOI;
        else if (!cpu_ie) state_d = ST_IDLE;
      end
      ST_CLEAR:    if (io_gnt) state_d = irq_eoi ? ST_IDLE : ST_WAIT_EOI;
      ST_WAIT_EOI: if (irq_eoi) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  // Outputs decode the registered state so reset drops the bus at once.
  assign io_req    = (state_q == ST_RD_PEND) || (state_q == ST_CLEAR);
  assign io_write  = (state_q == ST_CLEAR) && io_gnt;
  assign io_addr   = (state_q == ST_RD_PEND) ? PEND_ADDR :
                     (state_q == ST_CLEAR)   ? CLR_ADDR  : 4'd0;
  assign io_wdata  = (state_q == ST_CLEAR) ? (16'h1 << src_q) : 16'h0;
  assign irq_valid = (state_q == ST_PRESENT);
  assign irq_vec   = src_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef INTR_DISPATCH_STATS_EN
  logic [7:0]  spur_q;
  logic [15:0] disp_q;
  logic        spur_evt;

  assign spur_evt = (state_q == ST_RD_PEND) && cpu_ie && io_gnt && !pend_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spur_q <= '0;
      disp_q <= '0;
    end else begin
      if (spur_evt && (spur_q != '1))              spur_q <= spur_q + 8'd1;
      if (irq_valid && irq_ready && (disp_q != '1)) disp_q <= disp_q + 16'd1;
    end
  end

  assign spurious_count = spur_q;
  assign dispatch_count = disp_q;
`endif

endmodule

// File: doc/intr_dispatch.md
Name: intr_dispatch

Overview:
- CPU-side consumer of the interrupt controller's `interrupt` line, and an io-bus initiator toward that controller.
- On an enabled interrupt it reads the pending register and priority-encodes the lowest-numbered pending source.
- It presents that source as a vector to the CPU trap logic; on acceptance it clears software-clearable sources through the controller's clear register.
- It then waits for end-of-interrupt before it re-arms. It sits between the interrupt controller and the CPU's io-bus mux / trap unit.

Parameters:
- NSRC, 5, number of interrupt sources (bit i of pending = source i; 0 = uart, 1 = clock, 2 = timer, 3 = swi, 4 = sd).
- PEND_ADDR, 4'd0, io address of the pending register.
- CLR_ADDR, 4'd5, io address of the write-one-to-clear register.
- CLR_MASK, 5'b01110, sources that need a clear write after acceptance; level sources (uart, sd) are excluded.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- interrupt  in  1  level interrupt from the controller
- cpu_ie  in  1  CPU global interrupt enable
- io_req  out  1  io-bus request to the CPU io mux
- io_gnt  in  1  io-bus grant; a transfer occurs in any cycle with io_req & io_gnt
- io_write  out  1  write strobe; only high when io_req & io_gnt in CLEAR
- io_addr  out  4  io address; valid while io_req
- io_wdata  out  16  write data
- io_rdata  in  16  combinational read data for io_addr, same cycle
- irq_valid  out  1  vector offered to the CPU
- irq_vec  out  3  source index being offered
- irq_ready  in  1  CPU takes the trap; handshake completes on irq_valid & irq_ready
- irq_eoi  in  1  single-cycle end-of-interrupt pulse from the handler
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, async): state IDLE. io_req, io_write, irq_valid and busy are 0; io_addr, io_wdata and irq_vec are 0. Any bus request is dropped immediately, with no partial transfer.
- States: IDLE, RD_PEND, PRESENT, CLEAR, WAIT_EOI.
- IDLE: interrupt & cpu_ie -> RD_PEND next cycle.
- RD_PEND:
  - Drives io_req=1, io_addr=PEND_ADDR, io_write=0.
  - If cpu_ie falls before the grant -> IDLE.
  - On io_gnt, sample io_rdata[NSRC-1:0] in the same cycle.
  - If the sample is zero (spurious) -> IDLE.
  - Otherwise latch src = index of the lowest set bit -> PRESENT. Read latency is 1 cycle from grant to PRESENT.
- PRESENT:
  - irq_valid=1, irq_vec=src (registered, stable until the handshake).
  - On irq_ready: if CLR_MASK[src] -> CLEAR, else -> WAIT_EOI.
  - If cpu_ie falls before irq_ready -> IDLE, with no clear issued.
  - irq_valid drops the cycle after the handshake.
- CLEAR:
  - io_req=1, io_addr=CLR_ADDR, io_wdata = 16'h1 << src.
  - io_write = io_gnt (combinational). On grant -> WAIT_EOI.
  - cpu_ie is ignored here; an accepted interrupt is always cleared.
- WAIT_EOI: irq_eoi -> IDLE.
  - irq_eoi in any other state is ignored.
  - irq_eoi arriving in the same cycle as the CLEAR grant is not lost: the next state is IDLE.
- Re-arm: IDLE re-samples `interrupt` the cycle after returning. Still-pending or newly pending sources start a new dispatch, with no holdoff cycle.
- irq_ready is ignored outside PRESENT.
- Multiple pending sources: one source per dispatch, lowest index wins. Higher indices are served on later dispatches.

Optional Feature:
- INTR_DISPATCH_STATS_EN defined:
  - Adds outputs spurious_count[7:0] and dispatch_count[15:0].
  - Both are zero at reset and saturate at all-ones.
  - spurious_count increments on a zero pending read.
  - dispatch_count increments on each irq_valid & irq_ready.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package intr_pkg:
  - state enum intr_disp_state_t;
  - io address constants INTR_PEND_ADDR / INTR_STATUS_ADDR / INTR_ENABLE_ADDR / INTR_SET_ADDR / INTR_CLR_ADDR;
  - source index constants SRC_UART=0, SRC_CLOCK=1, SRC_TIMER=2, SRC_SWI=3, SRC_SD=4;
  - default CLR_MASK.
- One sub-module: intr_prio_enc. It is combinational NSRC -> {any, idx[2:0]}, lowest index first, and is reused by the CPU trap unit.

Test Plan:
- Pending=5'b00100, cpu_ie=1, io_gnt tied 1:
  - read at addr 0 in the cycle after interrupt rises;
  - irq_vec=2 two cycles later;
  - after irq_ready, exactly one write of addr 5, data 16'h0004;
  - then busy until irq_eoi.
- Pending=5'b10001: vec=0 (uart) with no clear write. After eoi with pending still 5'b10000, a second dispatch gives vec=4, again with no write.
- interrupt high, pending read returns 0: back to IDLE in 1 cycle, irq_valid never asserted, spurious_count=1 (with stats).
- io_gnt held low for 3 cycles in CLEAR: io_req stays high, io_write stays 0, exactly one write on the grant cycle.
- cpu_ie dropped while in PRESENT: irq_valid falls next cycle, no clear write, state IDLE.
- reset pulled low mid-CLEAR with io_req=1: io_req and irq_valid go 0 asynchronously, no write issued. After release, a fresh dispatch starts from IDLE.
